// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with per-digit dp/blank/flash masks and 16-level PWM.
// Optional hex glyphs for codes 10..15 when SEG_HEX_DECODE_EN is defined (otherwise they show "0").
module seg_scan_display #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int DIV_BITS     = 16,
    parameter  int FLASH_FRAMES = 64,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     flash,
    input  logic [3:0]                bright,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                seg,
    output logic [IDX_W-1:0]          count
);

    localparam int FR_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [DIV_BITS-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FR_W-1:0]       frame_q, frame_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic [IDX_W-1:0]      count_q, count_d;

    logic                  tick;
    logic                  duty_on;
    logic                  en;
    logic [NUM_DIGITS-1:0] digit_on;
    logic [3:0]            digit_code [NUM_DIGITS];

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
`ifdef SEG_HEX_DECODE_EN
            4'd10:   s = 7'h08;
            4'd11:   s = 7'h03;
            4'd12:   s = 7'h46;
            4'd13:   s = 7'h21;
            4'd14:   s = 7'h06;
            default: s = 7'h0E;
`else
            default: s = 7'h40;
`endif
        endcase
        return s;
    endfunction

    // Per-digit mask combination, independent of the scan position.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_code[gi] = digits[4*gi +: 4];
            assign digit_on[gi]   = ~blank[gi] & ~(flash[gi] & phase_q);
        end
    endgenerate

    assign tick    = &presc_q;
    assign duty_on = (presc_q[DIV_BITS-1 -: 4] <= bright);
    assign en      = digit_on[idx_q] & duty_on;

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (tick) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
                // Frame end: count frames and flip the flash phase every FLASH_FRAMES frames.
                if (frame_q == FR_W'(FLASH_FRAMES - 1)) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        an_d    = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d   = en ? {~dp[idx_q], decode(digit_code[idx_q])} : 8'hFF;
        count_d = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            count_q <= count_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign count = count_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (4 digits, 16-clock slots, 2-frame flash half-period).
// Expected pins come from a closed-form model of elapsed cycles since reset release.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int DB = 4;
    localparam int FF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp, blank, flash, bright;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  count;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    seg_scan_display #(
        .NUM_DIGITS  (ND),
        .DIV_BITS    (DB),
        .FLASH_FRAMES(FF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .digits(digits),
        .dp    (dp),
        .blank (blank),
        .flash (flash),
        .bright(bright),
        .an    (an),
        .seg   (seg),
        .count (count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_dec(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0: r = 7'h40;  4'd1: r = 7'h79;  4'd2: r = 7'h24;  4'd3: r = 7'h30;
            4'd4: r = 7'h19;  4'd5: r = 7'h12;  4'd6: r = 7'h02;  4'd7: r = 7'h78;
            4'd8: r = 7'h00;  4'd9: r = 7'h10;
`ifdef SEG_HEX_DECODE_EN
            4'd10: r = 7'h08; 4'd11: r = 7'h03; 4'd12: r = 7'h46;
            4'd13: r = 7'h21; 4'd14: r = 7'h06; default: r = 7'h0E;
`else
            default: r = 7'h40;
`endif
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock; expected pins reflect the state c = cycles elapsed since release.
    task automatic step(input string tag);
        int         c, pre, idx, phase;
        bit         en;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        c     = cyc;
        pre   = c % 16;
        idx   = (c / 16) % ND;
        phase = ((c / (16 * ND)) / FF) % 2;
        en    = !blank[idx] && !(flash[idx] && phase == 1) && (pre <= int'(bright));
        e_an  = en ? ~(4'(1) << idx) : 4'hF;
        e_seg = en ? {~dp[idx], ref_dec(digits[4*idx +: 4])} : 8'hFF;
        @(posedge clk);
        #1;
        cyc++;
        check({tag, ".an"}, 32'(an), 32'(e_an));
        check({tag, ".seg"}, 32'(seg), 32'(e_seg));
        check({tag, ".count"}, 32'(count), 32'(idx));
        check({tag, ".onehot"}, 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic check_dark(input string tag);
        check({tag, ".an"}, 32'(an), 32'hF);
        check({tag, ".seg"}, 32'(seg), 32'hFF);
        check({tag, ".count"}, 32'(count), 32'd0);
    endtask

    initial begin
        int lit;
        rst    = 1'b1;
        digits = 16'h4321;
        dp     = '0;
        blank  = '0;
        flash  = '0;
        bright = 4'd15;

        // Reset held three clocks: dark pins throughout.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_dark("reset");
        end
        rst = 1'b0;
        cyc = 0;

        // Basic scan of 4321.
        for (int i = 0; i < 64; i++) step("scan");

        // Decimal point and blank.
        dp    = 4'b0010;
        blank = 4'b1000;
        for (int i = 0; i < 64; i++) step("dpblank");
        dp    = '0;
        blank = '0;

        // Brightness: lit-cycle counts per frame.
        bright = 4'd0;
        lit    = 0;
        for (int i = 0; i < 64; i++) begin
            step("bright0");
            if (an != 4'hF) lit++;
        end
        check("bright0.lit", 32'(lit), 32'd4);
        bright = 4'd7;
        lit    = 0;
        for (int i = 0; i < 64; i++) begin
            step("bright7");
            if (an != 4'hF) lit++;
        end
        check("bright7.lit", 32'(lit), 32'd32);
        bright = 4'd15;

        // Flash on digit 0 across several flash phases, plus blank+flash on digit 3.
        flash = 4'b0001;
        for (int i = 0; i < 256; i++) step("flash");
        flash = 4'b1001;
        blank = 4'b1000;
        for (int i = 0; i < 256; i++) step("flashblank");
        flash = '0;
        blank = '0;

        // Hex codes.
        digits = 16'hFEDA;
        for (int i = 0; i < 64; i++) step("hex");

        // Random inputs changing mid-slot.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                digits = 16'($urandom);
                dp     = 4'($urandom);
                blank  = 4'($urandom);
                flash  = 4'($urandom);
                bright = 4'($urandom);
            end
            step("rand");
        end

        // Mid-scan reset at idx=2, prescaler=9.
        digits = 16'h8765;
        dp     = '0;
        blank  = '0;
        flash  = '0;
        bright = 4'd15;
        while (cyc % 64 != 41) step("prerst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_dark("midrst");
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 32; i++) step("restart");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
